grid_cursor_select: RTL and testbench
=====================================

# grid_cursor_select

Parametrised successor to the board-cell selector: a 2-D cursor over a ROWS×COLS board driven by four edge-detected direction inputs, with a per-cell "taken" mask that makes each cell selectable at most once until cleared. It sits between the debounced button inputs and the game-logic/VGA layers, supplying the current cursor cell, the last accepted selection, and accept/reject strobes.

## Interface
- ROWS, 5, board rows (≥1)
- COLS, 5, board columns (≥1)
- WRAP, 1, 1 = cursor wraps at board edges; 0 = cursor saturates at edges
- Derived: N = ROWS*COLS; IW = $clog2(N+1); RW = max(1,$clog2(ROWS)); CW = max(1,$clog2(COLS))

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  action gate; edge detectors keep tracking when low
- move_up, move_down, move_left, move_right  in  1 each  level inputs, act on rising edge
- select  in  1  level input, acts on rising edge
- clear_marks  in  1  level; clears taken mask while high
- cursor  out  IW  1-based cell index of cursor, row*COLS+col+1
- cur_row  out  RW  cursor row, 0-based
- cur_col  out  CW  cursor column, 0-based
- selected_cell  out  IW  last accepted cell (1-based), 0 = none
- is_selected  out  1  level: cursor sits on the last accepted selection, no move since
- sel_valid  out  1  one-cycle pulse: select accepted
- sel_reject  out  1  one-cycle pulse: select on taken cell
- taken  out  N  bit (i-1) set = cell i taken
- full  out  1  all N cells taken

## Operation
- Edge detect: per input (4 moves + select), registered previous value; edge = in & ~prev. prev registers update every cycle regardless of enable.
- Action cycle requires enable=1. Priority per cycle: clear_marks > move > select.
- Moves: single move edge acts; priority among simultaneous edges up > down > left > right, others discarded (not deferred).
  - up: row-1; down: row+1; left: col-1; right: col+1.
  - At edge: WRAP=1 → row 0 up → ROWS-1, row ROWS-1 down → 0, same for columns (stays in same row/column). WRAP=0 → position unchanged, no error.
  - Any accepted move edge (including saturated no-op) clears is_selected.
- Select edge, no move edge same cycle:
  - taken[cursor-1]=0 → set bit, selected_cell ← cursor, is_selected ← 1, sel_valid pulse.
  - taken[cursor-1]=1 → sel_reject pulse; selected_cell, is_selected, mask unchanged.
- Select edge coincident with any move edge: select discarded, move executes.
- clear_marks=1 (enable=1): taken ← 0, selected_cell ← 0, is_selected ← 0; move/select edges that cycle discarded. Cursor position kept.
- full = &taken, registered alongside mask.
- cursor, cur_row, cur_col mutually consistent every cycle.

## Timing
- rst low (any time, async): cursor=1, cur_row=0, cur_col=0, selected_cell=0, is_selected=0, sel_valid=0, sel_reject=0, taken=0, full=0, all prev registers=0. Input held high across reset release counts as an edge on the first sampling clock.
- Latency: input low at posedge k-1 and high at posedge k → outputs updated immediately after posedge k (one registered stage, no combinational input→output path).
- sel_valid/sel_reject high exactly one cycle; never both high; held select produces one pulse only.
- Held direction input moves one cell only; must drop low ≥1 sampled cycle to re-arm.
- Edge arriving while enable=0 is consumed and lost; raising enable while input held does not act.
- full rises the cycle after last free cell accepted; falls the cycle after clear_marks sampled.

## Test plan
- Reset then 3× move_right pulses, 2× move_down (5×5, WRAP=1) → cur_row=2, cur_col=3, cursor=14; all other outputs at reset values.
- From cell 1: move_left → cursor=5; move_up → cursor=25; with WRAP=0 same stimulus → cursor stays 1.
- select on cell 14 → sel_valid 1 cycle, selected_cell=14, taken[13]=1, is_selected=1; second select → sel_reject 1 cycle, no change; move_right → is_selected=0, selected_cell stays 14.
- move_right and select rising same cycle at cell 1 → cursor=2, no pulse, taken=0; move_up+move_left same cycle → only up applied.
- Select all 25 cells via scan → full=1 after 25th sel_valid; clear_marks one cycle → taken=0, full=0, selected_cell=0, cursor unchanged.
- Assert rst mid-scan asynchronously (between clocks) → outputs at reset values before next edge; hold move_down across release → first clock moves cursor to 6.

Source files
------------

// File: rtl/grid_cursor_select.sv
// 2-D cursor over a ROWS x COLS board with edge-detected moves and a per-cell
// "taken" mask that lets each cell be accepted at most once until cleared.
module grid_cursor_select #(
    parameter int ROWS = 5,
    parameter int COLS = 5,
    parameter int WRAP = 1,
    localparam int N  = ROWS * COLS,
    localparam int IW = $clog2(N + 1),
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          move_up,
    input  logic          move_down,
    input  logic          move_left,
    input  logic          move_right,
    input  logic          select,
    input  logic          clear_marks,
    output logic [IW-1:0] cursor,
    output logic [RW-1:0] cur_row,
    output logic [CW-1:0] cur_col,
    output logic [IW-1:0] selected_cell,
    output logic          is_selected,
    output logic          sel_valid,
    output logic          sel_reject,
    output logic [N-1:0]  taken,
    output logic          full
);

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    logic prev_up, prev_down, prev_left, prev_right, prev_select;
    logic up_edge, down_edge, left_edge, right_edge, select_edge, any_move;
    logic [RW-1:0] row_next;
    logic [CW-1:0] col_next;
    logic [IW-1:0] cell_idx;
    logic [N-1:0]  cell_bit;
    logic          cell_taken;

    assign up_edge     = move_up    & ~prev_up;
    assign down_edge   = move_down  & ~prev_down;
    assign left_edge   = move_left  & ~prev_left;
    assign right_edge  = move_right & ~prev_right;
    assign select_edge = select     & ~prev_select;
    assign any_move    = up_edge | down_edge | left_edge | right_edge;

    assign cell_idx   = IW'(cur_row) * IW'(COLS) + IW'(cur_col);
    assign cursor     = cell_idx + IW'(1);
    assign cell_bit   = N'(1) << cell_idx;
    assign cell_taken = |(taken & cell_bit);

    // Only the highest-priority move edge is applied; edges saturate when WRAP=0.
    always_comb begin
        row_next = cur_row;
        col_next = cur_col;
        if (up_edge) begin
            if (cur_row == '0) row_next = (WRAP != 0) ? ROW_MAX : cur_row;
            else               row_next = cur_row - RW'(1);
        end else if (down_edge) begin
            if (cur_row == ROW_MAX) row_next = (WRAP != 0) ? '0 : cur_row;
            else                    row_next = cur_row + RW'(1);
        end else if (left_edge) begin
            if (cur_col == '0) col_next = (WRAP != 0) ? COL_MAX : cur_col;
            else               col_next = cur_col - CW'(1);
        end else if (right_edge) begin
            if (cur_col == COL_MAX) col_next = (WRAP != 0) ? '0 : cur_col;
            else                    col_next = cur_col + CW'(1);
        end
    end

    // Edge history tracks inputs every cycle so edges seen while disabled are lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_up     <= 1'b0;
            prev_down   <= 1'b0;
            prev_left   <= 1'b0;
            prev_right  <= 1'b0;
            prev_select <= 1'b0;
        end else begin
            prev_up     <= move_up;
            prev_down   <= move_down;
            prev_left   <= move_left;
            prev_right  <= move_right;
            prev_select <= select;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_row       <= '0;
            cur_col       <= '0;
            selected_cell <= '0;
            is_selected   <= 1'b0;
            sel_valid     <= 1'b0;
            sel_reject    <= 1'b0;
            taken         <= '0;
            full          <= 1'b0;
        end else begin
            sel_valid  <= 1'b0;
            sel_reject <= 1'b0;
            if (enable) begin
                if (clear_marks) begin
                    taken         <= '0;
                    full          <= 1'b0;
                    selected_cell <= '0;
                    is_selected   <= 1'b0;
                end else if (any_move) begin
                    cur_row     <= row_next;
                    cur_col     <= col_next;
                    is_selected <= 1'b0;
                end else if (select_edge) begin
                    if (cell_taken) begin
                        sel_reject <= 1'b1;
                    end else begin
                        taken         <= taken | cell_bit;
                        full          <= &(taken | cell_bit);
                        selected_cell <= cursor;
                        is_selected   <= 1'b1;
                        sel_valid     <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_grid_cursor_select.sv
// Scoreboard bench: drives a WRAP=0 and a WRAP=1 instance with the same inputs
// and checks both against an abstract board model every cycle.
module tb_grid_cursor_select;

    localparam int ROWS = 5;
    localparam int COLS = 5;
    localparam int N    = ROWS * COLS;

    logic clk = 1'b0;
    logic rst;
    logic enable, move_up, move_down, move_left, move_right, select, clear_marks;

    logic [4:0]   c_cursor   [2];
    logic [2:0]   c_row      [2];
    logic [2:0]   c_col      [2];
    logic [4:0]   c_sel      [2];
    logic         c_is_sel   [2];
    logic         c_valid    [2];
    logic         c_reject   [2];
    logic [N-1:0] c_taken    [2];
    logic         c_full     [2];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int cursor;
        int row;
        int col;
        int sel;
        int is_sel;
        int valid;
        int reject;
        int taken;
        int full;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int m_row   [2];
    int m_col   [2];
    int m_sel   [2];
    int m_is    [2];
    bit m_taken [2][N];
    bit p_up, p_down, p_left, p_right, p_select;

    always #5 clk = ~clk;

    grid_cursor_select #(.ROWS(ROWS), .COLS(COLS), .WRAP(0)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable),
        .move_up(move_up), .move_down(move_down), .move_left(move_left),
        .move_right(move_right), .select(select), .clear_marks(clear_marks),
        .cursor(c_cursor[0]), .cur_row(c_row[0]), .cur_col(c_col[0]),
        .selected_cell(c_sel[0]), .is_selected(c_is_sel[0]),
        .sel_valid(c_valid[0]), .sel_reject(c_reject[0]),
        .taken(c_taken[0]), .full(c_full[0])
    );

    grid_cursor_select #(.ROWS(ROWS), .COLS(COLS), .WRAP(1)) dut_wrap (
        .clk(clk), .rst(rst), .enable(enable),
        .move_up(move_up), .move_down(move_down), .move_left(move_left),
        .move_right(move_right), .select(select), .clear_marks(clear_marks),
        .cursor(c_cursor[1]), .cur_row(c_row[1]), .cur_col(c_col[1]),
        .selected_cell(c_sel[1]), .is_selected(c_is_sel[1]),
        .sel_valid(c_valid[1]), .sel_reject(c_reject[1]),
        .taken(c_taken[1]), .full(c_full[1])
    );

    task automatic chk(input string name, input int w, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s wrap=%0d actual=%0d required=%0d", name, w, act, req);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_row[w] = 0;
            m_col[w] = 0;
            m_sel[w] = 0;
            m_is[w]  = 0;
            for (int i = 0; i < N; i++) m_taken[w][i] = 1'b0;
        end
        p_up = 0; p_down = 0; p_left = 0; p_right = 0; p_select = 0;
    endtask

    // Board rules applied to the inputs presented at the coming rising edge.
    task automatic model_step(input bit en, input bit up, input bit dn, input bit lf,
                              input bit rt, input bit sl, input bit clr);
        bit eu, ed, el, er, es;
        exp_t e;
        int idx, cnt;
        eu = up && !p_up;  ed = dn && !p_down;  el = lf && !p_left;
        er = rt && !p_right;  es = sl && !p_select;
        p_up = up; p_down = dn; p_left = lf; p_right = rt; p_select = sl;
        for (int w = 0; w < 2; w++) begin
            e.valid = 0;
            e.reject = 0;
            if (en) begin
                if (clr) begin
                    for (int i = 0; i < N; i++) m_taken[w][i] = 1'b0;
                    m_sel[w] = 0;
                    m_is[w]  = 0;
                end else if (eu || ed || el || er) begin
                    if (eu) begin
                        if (w == 1) m_row[w] = (m_row[w] + ROWS - 1) % ROWS;
                        else if (m_row[w] > 0) m_row[w] = m_row[w] - 1;
                    end else if (ed) begin
                        if (w == 1) m_row[w] = (m_row[w] + 1) % ROWS;
                        else if (m_row[w] < ROWS - 1) m_row[w] = m_row[w] + 1;
                    end else if (el) begin
                        if (w == 1) m_col[w] = (m_col[w] + COLS - 1) % COLS;
                        else if (m_col[w] > 0) m_col[w] = m_col[w] - 1;
                    end else begin
                        if (w == 1) m_col[w] = (m_col[w] + 1) % COLS;
                        else if (m_col[w] < COLS - 1) m_col[w] = m_col[w] + 1;
                    end
                    m_is[w] = 0;
                end else if (es) begin
                    idx = m_row[w] * COLS + m_col[w];
                    if (m_taken[w][idx]) begin
                        e.reject = 1;
                    end else begin
                        m_taken[w][idx] = 1'b1;
                        m_sel[w] = idx + 1;
                        m_is[w]  = 1;
                        e.valid  = 1;
                    end
                end
            end
            e.cursor = m_row[w] * COLS + m_col[w] + 1;
            e.row    = m_row[w];
            e.col    = m_col[w];
            e.sel    = m_sel[w];
            e.is_sel = m_is[w];
            e.taken  = 0;
            cnt = 0;
            for (int i = 0; i < N; i++) begin
                if (m_taken[w][i]) begin
                    e.taken = e.taken + (1 << i);
                    cnt++;
                end
            end
            e.full = (cnt == N) ? 1 : 0;
            if (w == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    // Called aligned to a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input bit en, input bit up, input bit dn, input bit lf,
                                 input bit rt, input bit sl, input bit clr);
        enable = en; move_up = up; move_down = dn; move_left = lf;
        move_right = rt; select = sl; clear_marks = clr;
        model_step(en, up, dn, lf, rt, sl, clr);
        @(negedge clk);
    endtask

    task automatic pulse(input bit up, input bit dn, input bit lf, input bit rt, input bit sl);
        applyStimulus(1, up, dn, lf, rt, sl, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkOutput(input int w, input exp_t e);
        chk("cursor",        w, int'(c_cursor[w]), e.cursor);
        chk("cur_row",       w, int'(c_row[w]),    e.row);
        chk("cur_col",       w, int'(c_col[w]),    e.col);
        chk("selected_cell", w, int'(c_sel[w]),    e.sel);
        chk("is_selected",   w, int'(c_is_sel[w]), e.is_sel);
        chk("sel_valid",     w, int'(c_valid[w]),  e.valid);
        chk("sel_reject",    w, int'(c_reject[w]), e.reject);
        chk("taken",         w, int'(c_taken[w]),  e.taken);
        chk("full",          w, int'(c_full[w]),   e.full);
    endtask

    task automatic check_reset_vals();
        exp_t e;
        e = '{cursor: 1, row: 0, col: 0, sel: 0, is_sel: 0, valid: 0, reject: 0, taken: 0, full: 0};
        for (int w = 0; w < 2; w++) checkOutput(w, e);
    endtask

    // Asynchronous reset asserted between edges; optionally hold move_down across release.
    task automatic do_reset(input bit hold_down);
        #2 rst = 1'b0;
        #1 check_reset_vals();
        model_reset();
        enable = 1; move_up = 0; move_left = 0; move_right = 0; select = 0;
        clear_marks = 0; move_down = hold_down;
        #1 rst = 1'b1;
        if (hold_down) applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                checkOutput(0, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                checkOutput(1, e);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog time limit expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin : driver
        rst = 1'b0;
        enable = 0; move_up = 0; move_down = 0; move_left = 0; move_right = 0;
        select = 0; clear_marks = 0;
        model_reset();
        #1 check_reset_vals();
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 3; i++) pulse(0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) pulse(0, 1, 0, 0, 0);
        chk("plan_cursor14", 1, int'(c_cursor[1]), 14);
        chk("plan_row2",     1, int'(c_row[1]), 2);
        chk("plan_col3",     1, int'(c_col[1]), 3);

        pulse(0, 0, 0, 0, 1);
        chk("plan_sel14", 1, int'(c_sel[1]), 14);
        chk("plan_taken13", 1, int'(c_taken[1][13]), 1);
        pulse(0, 0, 0, 0, 1);
        chk("plan_sel14_kept", 1, int'(c_sel[1]), 14);
        pulse(0, 0, 0, 1, 0);
        chk("plan_isel_clear", 1, int'(c_is_sel[1]), 0);

        do_reset(0);
        pulse(0, 0, 1, 0, 0);
        chk("plan_left_wrap", 1, int'(c_cursor[1]), 5);
        chk("plan_left_sat",  0, int'(c_cursor[0]), 1);
        pulse(1, 0, 0, 0, 0);
        chk("plan_up_wrap", 1, int'(c_cursor[1]), 25);
        chk("plan_up_sat",  0, int'(c_cursor[0]), 1);

        do_reset(0);
        pulse(0, 0, 0, 1, 1);
        chk("plan_move_beats_sel", 1, int'(c_cursor[1]), 2);
        chk("plan_no_taken", 1, int'(c_taken[1]), 0);
        pulse(1, 0, 1, 0, 0);
        chk("plan_up_over_left", 1, int'(c_cursor[1]), 22);

        do_reset(0);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                pulse(0, 0, 0, 0, 1);
                pulse(0, 0, 0, 1, 0);
            end
            pulse(0, 1, 0, 0, 0);
        end
        chk("plan_full", 1, int'(c_full[1]), 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        chk("plan_clear_full",  1, int'(c_full[1]), 0);
        chk("plan_clear_sel",   1, int'(c_sel[1]), 0);
        chk("plan_clear_cursor", 1, int'(c_cursor[1]), 1);

        for (int i = 0; i < 4; i++) begin
            pulse(0, 0, 0, 0, 1);
            pulse(0, 0, 0, 1, 0);
        end
        do_reset(1);
        chk("plan_held_down", 1, int'(c_cursor[1]), 6);

        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        chk("plan_disabled_edge_lost", 1, int'(c_cursor[1]), 6);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 9) != 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
